// File: rtl/uart_word_bridge_pkg.sv
// Shared state encoding and sizing helpers for the UART word bridge.
package uart_bridge_pkg;

   typedef enum logic [2:0] {
      ST_RX       = 3'd0,
      ST_START    = 3'd1,
      ST_WAIT     = 3'd2,
      ST_TX_SEND  = 3'd3,
      ST_TX_GUARD = 3'd4,
      ST_TX_DRAIN = 3'd5
   } bridge_state_e;

   function automatic int bytes_per_word(input int n);
      return n / 32'sd8;
   endfunction

   function automatic int timeout_width(input int t);
      return (t < 32'sd1) ? 32'sd1 : $clog2(t + 32'sd1);
   endfunction

   function automatic int count_width(input int n);
      return (n < 32'sd2) ? 32'sd1 : $clog2(n);
   endfunction

endpackage

// File: rtl/word_byte_shifter.sv
// Byte-granular shift register used for rx word assembly and tx serialisation.
module word_byte_shifter #(
   parameter int N         = 16,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] load_data,
   input  logic         shift_in,
   input  logic [7:0]   byte_in,
   input  logic         shift_out,
   output logic [N-1:0] word
);

   logic [N-1:0] word_r;
   logic [N-1:0] ins_s;
   logic [N-1:0] outs_s;

   // Both directions move the word one byte toward the end that leaves first.
   always_comb begin
      if (MSB_FIRST) begin
         ins_s  = N'({word_r, byte_in});
         outs_s = N'({word_r, 8'h00});
      end else begin
         ins_s  = N'({byte_in, word_r} >> 8);
         outs_s = N'({8'h00, word_r} >> 8);
      end
   end

   // Word register: load has priority over shifting.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_r <= '0;
      end else if (load) begin
         word_r <= load_data;
      end else if (shift_in) begin
         word_r <= ins_s;
      end else if (shift_out) begin
         word_r <= outs_s;
      end
   end

   assign word = word_r;

endmodule

// File: rtl/uart_word_bridge.sv
// Bridges byte-wide UART traffic to an N-bit BRAM frame and serialises the engine result back.
module uart_word_bridge
   import uart_bridge_pkg::*;
#(
   parameter int N         = 16,
   parameter int ABITS     = 8,
   parameter int NWORDS    = 2,
   parameter bit MSB_FIRST = 1'b1,
   parameter int TIMEOUT   = 1250
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_valid,
   input  logic [7:0]       rx_byte,
   output logic [ABITS-1:0] wr_addr,
   output logic [N-1:0]     wr_data,
   output logic             wr_en,
   output logic             start,
   output logic             busy,
   input  logic             done,
   input  logic [N-1:0]     result,
   input  logic             tx_busy,
   output logic [7:0]       tx_byte,
   output logic             tx_valid,
   output logic             frame_err
);

   localparam int B   = bytes_per_word(N);
   localparam int BCW = count_width(B);
   localparam int TW  = timeout_width(TIMEOUT);
   localparam logic [BCW-1:0]   B_LAST = BCW'(B - 32'sd1);
   localparam logic [ABITS-1:0] W_LAST = ABITS'(NWORDS - 32'sd1);
   localparam logic [TW-1:0]    T_LAST = TW'(TIMEOUT - 32'sd1);
   localparam bit               TO_EN  = (TIMEOUT > 32'sd0);

   bridge_state_e    state_r;
   logic [BCW-1:0]   b_r;
   logic [ABITS-1:0] w_r;
   logic [TW-1:0]    idle_r;
   logic [BCW-1:0]   tx_cnt_r;
   logic [ABITS-1:0] wr_addr_r;
   logic             wr_en_r;
   logic             start_r;
   logic             busy_r;
   logic [7:0]       tx_byte_r;
   logic             tx_valid_r;
   logic             frame_err_r;
   logic             rx_shift_s;
   logic             tx_load_s;
   logic             tx_shift_s;
   logic [N-1:0]     rx_word_s;
   logic [N-1:0]     tx_word_s;

   function automatic logic [7:0] lead_byte(input logic [N-1:0] w);
      if (MSB_FIRST) begin
         return w[N-1 -: 8];
      end else begin
         return w[7:0];
      end
   endfunction

   // Shifter strobes derived from the current state.
   always_comb begin
      rx_shift_s = rx_valid && (state_r == ST_RX);
      tx_load_s  = done && (state_r == ST_WAIT);
      tx_shift_s = (state_r == ST_TX_SEND);
   end

   word_byte_shifter #(.N(N), .MSB_FIRST(MSB_FIRST)) u_rx_shift (
      .clk       (clk),
      .rst       (rst),
      .load      (1'b0),
      .load_data ({N{1'b0}}),
      .shift_in  (rx_shift_s),
      .byte_in   (rx_byte),
      .shift_out (1'b0),
      .word      (rx_word_s)
   );

   word_byte_shifter #(.N(N), .MSB_FIRST(MSB_FIRST)) u_tx_shift (
      .clk       (clk),
      .rst       (rst),
      .load      (tx_load_s),
      .load_data (result),
      .shift_in  (1'b0),
      .byte_in   (8'h00),
      .shift_out (tx_shift_s),
      .word      (tx_word_s)
   );

   // Frame control FSM; every output is a register written here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_RX;
         b_r         <= '0;
         w_r         <= '0;
         idle_r      <= '0;
         tx_cnt_r    <= '0;
         wr_addr_r   <= '0;
         wr_en_r     <= 1'b0;
         start_r     <= 1'b0;
         busy_r      <= 1'b0;
         tx_byte_r   <= 8'h00;
         tx_valid_r  <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         wr_en_r     <= 1'b0;
         start_r     <= 1'b0;
         tx_valid_r  <= 1'b0;
         frame_err_r <= 1'b0;
         // A byte arriving outside RX has nowhere to go: drop it and flag overrun.
         if (rx_valid && (state_r != ST_RX)) begin
            frame_err_r <= 1'b1;
         end
         case (state_r)
            ST_RX: begin
               if (rx_valid) begin
                  idle_r <= '0;
                  if (b_r == B_LAST) begin
                     b_r       <= '0;
                     wr_en_r   <= 1'b1;
                     wr_addr_r <= w_r;
                     if (w_r == W_LAST) begin
                        state_r <= ST_START;
                     end else begin
                        w_r <= w_r + ABITS'(1);
                     end
                  end else begin
                     b_r <= b_r + BCW'(1);
                  end
               end else if (TO_EN && ((b_r != '0) || (w_r != '0))) begin
                  if (idle_r == T_LAST) begin
                     b_r         <= '0;
                     w_r         <= '0;
                     idle_r      <= '0;
                     frame_err_r <= 1'b1;
                  end else begin
                     idle_r <= idle_r + TW'(1);
                  end
               end else begin
                  idle_r <= '0;
               end
            end
            ST_START: begin
               start_r <= 1'b1;
               busy_r  <= 1'b1;
               w_r     <= '0;
               state_r <= ST_WAIT;
            end
            ST_WAIT: begin
               if (done) begin
                  tx_byte_r  <= lead_byte(result);
                  tx_valid_r <= 1'b1;
                  tx_cnt_r   <= '0;
                  state_r    <= ST_TX_SEND;
               end
            end
            ST_TX_SEND: begin
               state_r <= ST_TX_GUARD;
            end
            ST_TX_GUARD: begin
               state_r <= ST_TX_DRAIN;
            end
            ST_TX_DRAIN: begin
               if (!tx_busy) begin
                  if (tx_cnt_r == B_LAST) begin
                     busy_r  <= 1'b0;
                     state_r <= ST_RX;
                  end else begin
                     tx_cnt_r   <= tx_cnt_r + BCW'(1);
                     tx_byte_r  <= lead_byte(tx_word_s);
                     tx_valid_r <= 1'b1;
                     state_r    <= ST_TX_SEND;
                  end
               end
            end
            default: begin
               state_r <= ST_RX;
            end
         endcase
      end
   end

   assign wr_addr   = wr_addr_r;
   assign wr_data   = rx_word_s;
   assign wr_en     = wr_en_r;
   assign start     = start_r;
   assign busy      = busy_r;
   assign tx_byte   = tx_byte_r;
   assign tx_valid  = tx_valid_r;
   assign frame_err = frame_err_r;

endmodule

// File: doc/uart_word_bridge.md
# uart_word_bridge

Parametrised bridge between the byte-wide UART core and the N-bit datapath. It assembles received bytes into N-bit words, writes a frame of NWORDS words into the operand BRAM write port, and pulses `start` to the compute engine. It then waits for `done` and returns the engine's N-bit result as bytes to the UART transmitter. It generalises the fixed serial_to_parallel/parallel_to_serial pair with configurable word width, frame length and byte order, an inter-byte timeout resync, and overrun detection.

## Interface
Parameters:
- N, 16: word width in bits; multiple of 8, ≥ 8. B = N/8 bytes per word.
- ABITS, 8: BRAM address width.
- NWORDS, 2: words per frame; 1 ≤ NWORDS ≤ 2^ABITS.
- MSB_FIRST, 1: 1 = most significant byte first on both rx and tx; 0 = least significant byte first.
- TIMEOUT, 1250: idle clk cycles between rx bytes before a partial frame is discarded; 0 disables.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- rx_valid  in  1  one-cycle strobe, rx_byte valid (UART `received`)
- rx_byte  in  8  received byte
- wr_addr  out  ABITS  BRAM write address
- wr_data  out  N  BRAM write data
- wr_en  out  1  BRAM write enable, one cycle per word
- start  out  1  one-cycle pulse: frame complete in BRAM
- busy  out  1  high from start until last result byte is handed to the UART
- done  in  1  one-cycle pulse from engine: result valid
- result  in  N  engine result, sampled on done
- tx_busy  in  1  UART `is_transmitting`
- tx_byte  out  8  byte to transmit
- tx_valid  out  1  one-cycle pulse: send tx_byte
- frame_err  out  1  one-cycle pulse on timeout discard or overrun

## Operation
- States: RX, START, WAIT, TX_SEND, TX_GUARD, TX_DRAIN.
- RX: each rx_valid byte shifts into a word register (order per MSB_FIRST) and increments byte count b (0..B-1). On the B-th byte, the word is written to wr_addr = word index w (0..NWORDS-1), b clears, and w increments. After the NWORDS-th write, go to START.
- START: start = 1 for one cycle, busy set, w clears; go to WAIT.
- WAIT: on done, latch result into the tx shift register, byte counter = 0; go to TX_SEND.
- TX_SEND: tx_valid = 1 with the current byte; go to TX_GUARD.
- TX_GUARD: one cycle; tx_busy is ignored. Go to TX_DRAIN.
- TX_DRAIN: when tx_busy = 0, either go to TX_SEND for the next byte, or, after byte B, clear busy and return to RX.
- Timeout: in RX with (b,w) ≠ (0,0), an idle counter counts clk cycles since the last rx_valid. When it reaches TIMEOUT, b and w clear, frame_err pulses, and no write occurs. Words already written stay in BRAM but are overwritten by the next frame.
- Overrun: rx_valid in any state other than RX drops the byte and pulses frame_err. State is unchanged.
- done outside WAIT: ignored.
- rst: synchronously forces RX with b, w, counters and shift registers cleared. It abandons any in-flight frame or transmission.

## Timing
- Reset values: wr_addr 0, wr_data 0, wr_en 0, start 0, busy 0, tx_byte 0, tx_valid 0, frame_err 0.
- All outputs are registered.
- wr_en is high in the cycle after the rx_valid of a word's last byte; wr_addr and wr_data are valid in the same cycle.
- start is high in the cycle after the final wr_en. busy rises with start.
- First tx_valid is in the cycle after done. Consecutive tx_valid pulses are at least 3 cycles apart, gated by tx_busy.
- busy falls in the cycle after tx_busy is seen low following the last byte.
- frame_err is high in the cycle after the triggering event.

## Structure
- Shared package `uart_bridge_pkg`: state encoding constants, BYTES_PER_WORD = N/8, and the timeout counter width ($clog2(TIMEOUT+1)).
- One sub-module, `word_byte_shifter`, parametrised by N and MSB_FIRST, with load/shift-in/shift-out. It is instantiated twice: once for rx assembly and once for tx serialisation.

## Test plan
All scenarios use N = 16, NWORDS = 2, MSB_FIRST = 1 unless stated.
- Bytes 12 34 56 78 → wr (0, 0x1234), then wr (1, 0x5678); start one cycle after the second wr_en; busy = 1.
- done with result 0xBEEF, tx_busy modelled high for 10 cycles per byte → tx_valid with BE, then EF after tx_busy falls; busy = 0 afterward.
- TIMEOUT = 50: byte 12, then 50 idle cycles → frame_err pulse, no wr_en; then AA BB CC DD → wr (0, 0xAABB), wr (1, 0xCCDD).
- Byte 55 received in WAIT → frame_err pulse, no wr_en, still WAIT; subsequent done still transmits the result.
- rst after bytes 12 34 56 → all outputs at reset values; next 4 bytes write from address 0.
- N = 32, NWORDS = 1, MSB_FIRST = 0: bytes 01 02 03 04 → wr (0, 0x04030201); result 0x11223344 → tx 44 33 22 11.
